// File: rtl/echo_multi_if.sv
// echo_multi sample bus: input strobe, runtime controls and processed output.
// master drives samples and controls; slave is the echo stage.
interface echo_multi_if #(
   parameter int WIDTH    = 24,
   parameter int CHANNELS = 2,
   parameter int DLY_LOG2 = 14
);
   logic                      valid;
   logic [CHANNELS*WIDTH-1:0] audio_in;
   logic [DLY_LOG2-1:0]       delay;
   logic [2:0]                decay_shift;
   logic                      mode;
   logic                      bypass;
   logic [CHANNELS*WIDTH-1:0] audio_out;
   logic                      out_valid;

   modport master (
      output valid, audio_in, delay, decay_shift, mode, bypass,
      input  audio_out, out_valid
   );

   modport slave (
      input  valid, audio_in, delay, decay_shift, mode, bypass,
      output audio_out, out_valid
   );
endinterface

// File: rtl/echo_multi.sv
// Multi-channel echo/reverb stage: feed-forward or feedback delay line
// held in block RAM, saturating mix, three-stage strobe pipeline.
module echo_multi #(
   parameter int WIDTH    = 24,
   parameter int CHANNELS = 2,
   parameter int DLY_LOG2 = 14
) (
   input logic        clock,
   input logic        reset,
   echo_multi_if.slave bus
);

   localparam int DW    = CHANNELS * WIDTH;
   localparam int DEPTH = 2 ** DLY_LOG2;

   typedef logic [DLY_LOG2-1:0] addr_t;

   localparam addr_t            FILL_MAX = '1;
   localparam logic [WIDTH-1:0] SAT_MAX  = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] SAT_MIN  = {1'b1, {(WIDTH-1){1'b0}}};

   logic [DW-1:0] ram [DEPTH];
   logic [DW-1:0] ram_q;

   addr_t         wptr;
   addr_t         fill;
   addr_t         rd_addr;

   logic          s1_v;
   logic          s2_v;
   logic          accept;

   logic [DW-1:0] x1;
   addr_t         dly1;
   logic [2:0]    sh1;
   logic          mode1;
   logic          byp1;
   logic          d_en;

   logic [DW-1:0] out_nx;
   logic [DW-1:0] wr_nx;
   logic [DW-1:0] wr_q;
   logic [DW-1:0] out_q;

   // A strobe landing while the pipe is busy is dropped.
   assign accept  = bus.valid && !s1_v && !s2_v;
   assign rd_addr = wptr - bus.delay;

   // Stale RAM after reset is masked until enough samples were written.
   assign d_en = (dly1 != '0) && (fill >= dly1);

   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      logic signed [WIDTH-1:0] x;
      logic signed [WIDTH-1:0] d;
      logic signed [WIDTH-1:0] dsh;
      logic        [WIDTH:0]   s;
      logic        [WIDTH-1:0] y;

      assign x   = x1[c*WIDTH +: WIDTH];
      assign d   = d_en ? ram_q[c*WIDTH +: WIDTH] : '0;
      assign dsh = d >>> sh1;
      assign s   = {x[WIDTH-1], x} + {dsh[WIDTH-1], dsh};
      assign y   = (s[WIDTH] != s[WIDTH-1])
                 ? (s[WIDTH] ? SAT_MIN : SAT_MAX)
                 : s[WIDTH-1:0];

      assign out_nx[c*WIDTH +: WIDTH] = byp1  ? x : y;
      assign wr_nx[c*WIDTH +: WIDTH]  = mode1 ? y : x;
   end

   // Stage flags, registered output and pointer/fill bookkeeping.
   always_ff @(posedge clock) begin
      if (reset) begin
         s1_v  <= 1'b0;
         s2_v  <= 1'b0;
         out_q <= '0;
         wptr  <= '0;
         fill  <= '0;
      end else begin
         s1_v <= accept;
         s2_v <= s1_v;
         if (s1_v) begin
            out_q <= out_nx;
         end
         if (s2_v) begin
            wptr <= wptr + addr_t'(1);
            if (fill != FILL_MAX) begin
               fill <= fill + addr_t'(1);
            end
         end
      end
   end

   // Sample and control capture; no reset needed on pure datapath.
   always_ff @(posedge clock) begin
      if (accept) begin
         x1    <= bus.audio_in;
         dly1  <= bus.delay;
         sh1   <= bus.decay_shift;
         mode1 <= bus.mode;
         byp1  <= bus.bypass;
      end
      if (s1_v) begin
         wr_q <= wr_nx;
      end
   end

   // Delay line: synchronous read in S0, write at the end of S2.
   always_ff @(posedge clock) begin
      if (accept) begin
         ram_q <= ram[rd_addr];
      end
      if (s2_v && !reset) begin
         ram[wptr] <= wr_q;
      end
   end

   assign bus.audio_out = out_q;
   assign bus.out_valid = s2_v;

endmodule
